sync_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO: the design under test behind `fifo_if`, i.e. the responder on both the input handshake and the output handshake that the bench's driver and monitor exercise. Accepts packets on a valid/ready input port, buffers up to `DEPTH` entries and presents the oldest entry on a valid/ready output port. Provides occupancy and almost-full status for downstream flow control and for scoreboarding.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_if.sv | 36 +++
 rtl/fifo_mem.sv | 34 +++
 rtl/sync_fifo.sv | 93 +++++++++
 tb/tb_sync_fifo.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the synchronous FWFT FIFO and its testbench:
//   packet_t      - default payload type (32-bit word)
//   ptr_width()   - width of read/write pointers and of the occupancy count
//   addr_width()  - width of the storage index (pointer without wrap bit)
//   fifo_count_t  - occupancy type for the default depth
package fifo_pkg;

  typedef logic [31:0] packet_t;

  localparam int DEFAULT_DEPTH = 8;

  // Pointers carry one extra wrap bit above the storage index, so the
  // same width also holds an occupancy of 0..DEPTH.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  typedef logic [ptr_width(DEFAULT_DEPTH)-1:0] fifo_count_t;

endpackage

// File: rtl/fifo_if.sv
// fifo_if
// Handshake bundle around the FIFO.
//   in_valid/in_ready/packet_in    - producer side, valid/ready
//   out_valid/out_ready/packet_out - consumer side, valid/ready
//   count/almost_full              - occupancy status
// Modports:
//   master - the producer/consumer environment driving the FIFO
//   slave  - the FIFO itself
interface fifo_if #(
  parameter type PACKET_T = fifo_pkg::packet_t,
  parameter int  DEPTH    = 8
);
  import fifo_pkg::*;

  localparam int CW = ptr_width(DEPTH);

  logic          in_valid;
  logic          in_ready;
  PACKET_T       packet_in;
  logic          out_valid;
  logic          out_ready;
  PACKET_T       packet_out;
  logic [CW-1:0] count;
  logic          almost_full;

  modport master (
    output in_valid, packet_in, out_ready,
    input  in_ready, out_valid, packet_out, count, almost_full
  );

  modport slave (
    input  in_valid, packet_in, out_ready,
    output in_ready, out_valid, packet_out, count, almost_full
  );

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem
// Flop-array storage for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clock   - write clock
//   wr_en   - write strobe
//   wr_addr - write index
//   wr_data - write payload
//   rd_addr - read index
//   rd_data - combinational read payload
module fifo_mem
  import fifo_pkg::*;
#(
  parameter type PACKET_T = packet_t,
  parameter int  DEPTH    = 8
) (
  input  logic                         clock,
  input  logic                         wr_en,
  input  logic [addr_width(DEPTH)-1:0] wr_addr,
  input  PACKET_T                      wr_data,
  input  logic [addr_width(DEPTH)-1:0] rd_addr,
  output PACKET_T                      rd_data
);

  PACKET_T mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Synchronous first-word-fall-through FIFO. Holds up to DEPTH packets and
// presents the oldest one on the output port whenever it is non-empty.
//   clock - single clock, all state on its rising edge
//   reset - asynchronous, active-low
//   bus   - fifo_if slave: input handshake, output handshake, count and
//           registered almost_full (count >= AFULL_LEVEL)
module sync_fifo
  import fifo_pkg::*;
#(
  parameter type PACKET_T    = packet_t,
  parameter int  DEPTH       = 8,
  parameter int  AFULL_LEVEL = DEPTH - 2
) (
  input  logic  clock,
  input  logic  reset,
  fifo_if.slave bus
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = ptr_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          in_reset;
  logic          almost_full_q;
  logic          in_ready_int;
  logic          out_valid_int;
  logic          push;
  logic          pop;

  // Readiness depends only on state: in_reset keeps the input closed for
  // one cycle after reset release so the first accept is on the second edge.
  assign in_ready_int  = (count_q != FULL_CNT) && !in_reset;
  assign out_valid_int = (count_q != '0);

  assign push = bus.in_valid && in_ready_int;
  assign pop  = out_valid_int && bus.out_ready;

  // Simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // almost_full is registered from the next-state count so it changes on
  // the same edge as count itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_reset      <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      in_reset      <= 1'b0;
      count_q       <= count_next;
      almost_full_q <= (count_next >= AFULL_CNT);
      if (push) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

  fifo_mem #(
    .PACKET_T (PACKET_T),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (bus.packet_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (bus.packet_out)
  );

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = out_valid_int;
  assign bus.count       = count_q;
  assign bus.almost_full = almost_full_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
// Self-checking bench for sync_fifo (DEPTH = 8, AFULL_LEVEL = 6). Accepted
// packets are pushed into a scoreboard queue; every pop is compared with
// the queue head.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = ptr_width(DEPTH);

  logic clock = 1'b0;
  logic reset = 1'b0;

  int errors = 0;
  int checks = 0;

  packet_t sb [$];

  fifo_if #(.PACKET_T(packet_t), .DEPTH(DEPTH)) bus ();

  sync_fifo #(
    .PACKET_T    (packet_t),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (DEPTH - 2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Hard stop in case a wait never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Samples the handshakes at the falling edge, records accepted packets
  // in the scoreboard, then advances to 1 time unit after the rising edge.
  task automatic step(output logic pushed, output logic popped, output packet_t got);
    @(negedge clock);
    pushed = bus.in_valid && bus.in_ready;
    popped = bus.out_valid && bus.out_ready;
    got    = bus.packet_out;
    if (pushed) sb.push_back(bus.packet_in);
    @(posedge clock);
    #1;
  endtask

  function automatic packet_t sb_pop();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    logic pu, po;
    packet_t got, exp;
    reset = 1'b0;
    bus.in_valid  = 1'b1;
    bus.packet_in = 32'hA5;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL reset_count: got %0d required 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 0", bus.in_ready); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_almost_full: got %b required 0", bus.almost_full); end
    #1 reset = 1'b1;
    step(pu, po, got);
    checks++; if (pu !== 1'b0) begin errors++; $display("[TB] FAIL release_first_edge_accept: got %b required 0", pu); end
    step(pu, po, got);
    checks++; if (pu !== 1'b1) begin errors++; $display("[TB] FAIL release_second_edge_accept: got %b required 1", pu); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL release_out_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.packet_out !== 32'hA5) begin errors++; $display("[TB] FAIL release_packet_out: got %h required 000000a5", bus.packet_out); end
    checks++; if (bus.count !== CW'(1)) begin errors++; $display("[TB] FAIL release_count: got %0d required 1", bus.count); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step(pu, po, got);
    exp = sb_pop();
    checks++; if (po !== 1'b1 || got !== exp) begin errors++; $display("[TB] FAIL release_pop: got pop=%b data=%h required pop=1 data=%h", po, got, exp); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic pu, po;
    packet_t got;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      bus.packet_in = packet_t'(i);
      step(pu, po, got);
      checks++; if (pu !== 1'b1) begin errors++; $display("[TB] FAIL fill_accept_%0d: got %b required 1", i, pu); end
      checks++; if (bus.count !== CW'(i)) begin errors++; $display("[TB] FAIL fill_count_%0d: got %0d required %0d", i, bus.count, i); end
      checks++; if (bus.almost_full !== (i >= DEPTH - 2)) begin errors++; $display("[TB] FAIL fill_almost_full_%0d: got %b required %b", i, bus.almost_full, (i >= DEPTH - 2)); end
      checks++; if (bus.in_ready !== (i != DEPTH)) begin errors++; $display("[TB] FAIL fill_in_ready_%0d: got %b required %b", i, bus.in_ready, (i != DEPTH)); end
    end
    bus.packet_in = 32'd9;
    step(pu, po, got);
    checks++; if (pu !== 1'b0) begin errors++; $display("[TB] FAIL fill_ninth_held: got %b required 0", pu); end
    checks++; if (bus.count !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL fill_ninth_count: got %0d required %0d", bus.count, DEPTH); end
  endtask

  task automatic test_full_pop();
    logic pu, po;
    packet_t got, exp;
    bus.in_valid  = 1'b1;
    bus.packet_in = 32'd9;
    bus.out_ready = 1'b1;
    step(pu, po, got);
    exp = sb_pop();
    checks++; if (pu !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_no_push: got %b required 0", pu); end
    checks++; if (po !== 1'b1 || got !== 32'd1 || exp !== 32'd1) begin errors++; $display("[TB] FAIL full_pop_data: got pop=%b data=%h required pop=1 data=00000001", po, got); end
    checks++; if (bus.count !== CW'(7)) begin errors++; $display("[TB] FAIL full_pop_count: got %0d required 7", bus.count); end
    step(pu, po, got);
    exp = sb_pop();
    checks++; if (pu !== 1'b1) begin errors++; $display("[TB] FAIL full_repush_accept: got %b required 1", pu); end
    checks++; if (po !== 1'b1 || got !== 32'd2 || exp !== 32'd2) begin errors++; $display("[TB] FAIL full_repush_pop: got pop=%b data=%h required pop=1 data=00000002", po, got); end
    checks++; if (bus.count !== CW'(7)) begin errors++; $display("[TB] FAIL full_repush_count: got %0d required 7", bus.count); end
    bus.in_valid = 1'b0;
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      step(pu, po, got);
      if (po) begin
        exp = sb_pop();
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL full_drain_data: got %h required %h", got, exp); end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL full_drain_timeout: got %0d left required 0", sb.size()); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL full_drain_count: got %0d required 0", bus.count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic pu, po;
    packet_t got, exp;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.packet_in = 32'h100 + packet_t'(i);
      step(pu, po, got);
      checks++; if (pu !== 1'b1) begin errors++; $display("[TB] FAIL stream_accept_%0d: got %b required 1", i, pu); end
      if (i > 0) begin
        exp = sb_pop();
        checks++; if (po !== 1'b1 || got !== exp) begin errors++; $display("[TB] FAIL stream_pop_%0d: got pop=%b data=%h required pop=1 data=%h", i, po, got, exp); end
      end
      checks++; if (bus.count !== CW'(1)) begin errors++; $display("[TB] FAIL stream_count_%0d: got %0d required 1", i, bus.count); end
    end
    bus.in_valid = 1'b0;
    step(pu, po, got);
    exp = sb_pop();
    checks++; if (po !== 1'b1 || got !== exp) begin errors++; $display("[TB] FAIL stream_last_pop: got pop=%b data=%h required pop=1 data=%h", po, got, exp); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL stream_end_count: got %0d required 0", bus.count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic pu, po;
    packet_t got, exp;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.packet_in = 32'h200 + packet_t'(i);
      step(pu, po, got);
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(pu, po, got);
      checks++; if (bus.out_valid !== 1'b1 || bus.packet_out !== 32'h200) begin errors++; $display("[TB] FAIL hold_packet_out_%0d: got valid=%b data=%h required valid=1 data=00000200", c, bus.out_valid, bus.packet_out); end
    end
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10 && sb.size() != 0; n++) begin
      step(pu, po, got);
      if (po) begin
        exp = sb_pop();
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL hold_drain_data: got %h required %h", got, exp); end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL hold_drain_timeout: got %0d left required 0", sb.size()); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic pu, po;
    packet_t got, exp;
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    int bad  = 0;
    bus.in_valid = 1'b0;
    while (recv < 200 && cyc < 4000) begin
      if (!bus.in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
        bus.in_valid  = 1'b1;
        bus.packet_in = $urandom;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      step(pu, po, got);
      cyc++;
      if (pu) begin
        sent++;
        bus.in_valid = 1'b0;
      end
      if (po) begin
        recv++;
        exp = sb_pop();
        checks++;
        if (got !== exp) begin
          errors++;
          bad++;
          if (bad <= 5) $display("[TB] FAIL random_data_%0d: got %h required %h", recv, got, exp);
        end
      end
    end
    checks++; if (recv != 200) begin errors++; $display("[TB] FAIL random_timeout: got %0d packets required 200", recv); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL random_end_count: got %0d required 0", bus.count); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic pu, po;
    packet_t got, exp;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.packet_in = 32'h300 + packet_t'(i);
      step(pu, po, got);
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== CW'(5)) begin errors++; $display("[TB] FAIL areset_pre_count: got %0d required 5", bus.count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL areset_count: got %0d required 0", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL areset_in_ready: got %b required 0", bus.in_ready); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("[TB] FAIL areset_almost_full: got %b required 0", bus.almost_full); end
    sb.delete();
    @(posedge clock);
    #2 reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(pu, po, got);
      checks++; if (po !== 1'b0 || bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL areset_stale_%0d: got pop=%b count=%0d required pop=0 count=0", c, po, bus.count); end
    end
    bus.in_valid  = 1'b1;
    bus.packet_in = 32'h77;
    step(pu, po, got);
    checks++; if (pu !== 1'b1) begin errors++; $display("[TB] FAIL areset_repush: got %b required 1", pu); end
    bus.in_valid = 1'b0;
    step(pu, po, got);
    exp = sb_pop();
    checks++; if (po !== 1'b1 || got !== 32'h77 || exp !== 32'h77) begin errors++; $display("[TB] FAIL areset_repop: got pop=%b data=%h required pop=1 data=00000077", po, got); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL areset_end_count: got %0d required 0", bus.count); end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.packet_in = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fill();
    test_full_pop();
    test_stream();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
